csr_rmw_pipe: RTL
=================

// Module: csr_rmw_pipe
// PURPOSE
//  Parametrised CSR read-modify-write unit for the five-stage core; sits beside the ALU in EX.
//  Executes CSRRW/CSRRS/CSRRC and their immediate forms against an internal bank of NUM_CSR registers.
//  Read, modify and write are split over two pipelined cycles. Back-to-back accesses forward the pending write.
//  Supports valid/ready handshake, LSU stall, flush kill and illegal-access reporting.
// PARAMETERS
//  XLEN      32      CSR and operand width
//  NUM_CSR   8       implemented read/write CSRs; power of 2, 2..64
//  CSR_BASE  12'h300 address of CSR index 0; window is CSR_BASE .. CSR_BASE+NUM_CSR-1
// PORTS
//  CLK           in   1     clock
//  RSTN          in   1     reset, asynchronous, active-low
//  req_vld       in   1     CSR instruction present in EX
//  req_rdy       out  1     accept; = ~stall
//  req_op        in   2     01 RW, 10 RS(set), 11 RC(clear); 00 illegal
//  req_imm_sel   in   1     1: source = zero-extended req_zimm; 0: source = req_rs1_data
//  req_rs1_data  in   XLEN  rs1 operand
//  req_zimm      in   5     uimm field
//  req_addr      in   12    CSR address
//  req_rd_zero   in   1     rd==x0 (RW only: read is suppressed)
//  req_src_zero  in   1     rs1==x0 / uimm==0 (RS/RC only: write is suppressed)
//  stall         in   1     LSU not ready; freezes acceptance and response
//  flush         in   1     pipeline kill
//  rsp_vld       out  1     response valid, one cycle after accept
//  rsp_rdata     out  XLEN  old CSR value for rd writeback
//  rsp_illegal   out  1     illegal access; raises exception in MEM
// BEHAVIOUR
//  - Reset: rsp_vld=0, rsp_rdata=0, rsp_illegal=0, pending write cleared, all CSRs=0.
//  - Accept = req_vld & ~stall & ~flush.
//  - Cycle T (accept):
//    - old = bank[idx], or the pending wdata when the pending write targets the same idx (bypass).
//    - new = RW: src; RS: old|src; RC: old&~src.
//  - Edge T+1:
//    - rsp_vld=1; rsp_rdata = old, or 0 when RW & rd_zero.
//    - Pending write {idx,new} is registered unless src_zero on RS/RC, or the access is illegal.
//  - Edge T+2: pending write commits to the bank. Throughput is one access per cycle.
//  - Not accepted & ~stall: rsp_vld=0 next edge. stall=1: rsp_* hold their values; the pending write still commits.
//  - flush=1 (priority over stall): at next edge rsp_vld=0, rsp_illegal=0, rsp_rdata=0, pending write discarded.
//  - Illegal access:
//    - Conditions: addr outside window (and not a counter); req_op==00; write to a read-only address (addr[11:10]==2'b11).
//    - Response: rsp_illegal=1, rsp_rdata=0, no write.
//    - Exception: RS/RC with src_zero to a read-only address is legal (pure read).
//  - Index = addr - CSR_BASE, truncated to $clog2(NUM_CSR) bits after the range check; no wrap.
//  - Reset mid-operation: a pending write is lost; bank returns to 0.
// CONFIGURATION
//  - CSR_COUNTER_EN defined:
//    - 64-bit cycle counter, +1 every CLK, wraps 2^64-1 -> 0.
//    - Read-only at 12'hC00 (bits 31:0) and 12'hC80 (bits 63:32). For XLEN=64, C00 returns all 64 bits and C80 is illegal.
//    - Read returns the value sampled in the accept cycle.
//  - CSR_COUNTER_EN undefined: no counter; C00/C80 are illegal like any out-of-window address.
// STRUCTURE
//  - csr_pkg: op encoding localparams (CSR_OP_RW/RS/RC), counter address constants, read-only address-class helper function.
//  - Sub-module csr_bank: NUM_CSR x XLEN flops, one sync write port, one async read port, async reset.
//  - Top holds the decode, RMW datapath, bypass, response and pending-write registers, and the optional counter.
// TESTING
//  1. CSRRW 0x300 src=0xDEADBEEF, then CSRRS 0x300 src=0x0000_00F0 next cycle -> 2nd rdata=0xDEADBEEF (bypass); bank=0xDEADBEFF.
//  2. CSRRC 0x301 (val 0xFF) imm uimm=0x0F -> rdata=0xFF, bank=0xF0. Same op with src_zero=1 -> bank unchanged.
//  3. stall=1 for 3 cycles with req_vld=1 -> req_rdy=0, rsp held; accepted on the first cycle stall=0; exactly one rsp_vld pulse.
//  4. flush in the cycle after CSRRW 0x302 src=5 -> rsp_vld=0 next edge; bank[2] keeps its old value.
//  5. Access 0x308 (NUM_CSR=8), op=00, and CSRRW 0xC00 -> rsp_illegal=1, rdata=0, no bank change.
//  6. CSR_COUNTER_EN: 10 cycles after reset, CSRRS 0xC00 src_zero -> rdata=10 (±accept offset, checked against the model).
//     Undefined: same access -> rsp_illegal=1.

Source files
------------

// File: rtl/csr_rmw_pipe_pkg.sv
// Shared definitions for the CSR read-modify-write unit: op encodings,
// counter addresses, access decode and the read-only address-class helper.
package csr_rmw_pipe_pkg;

  localparam logic [1:0] CSR_OP_ILL = 2'b00;
  localparam logic [1:0] CSR_OP_RW  = 2'b01;
  localparam logic [1:0] CSR_OP_RS  = 2'b10;
  localparam logic [1:0] CSR_OP_RC  = 2'b11;

  localparam logic [11:0] CSR_ADDR_CYCLE  = 12'hC00;
  localparam logic [11:0] CSR_ADDR_CYCLEH = 12'hC80;

  typedef struct packed {
    logic op_ok;    // encoding names a real operation
    logic wr_req;   // access intends to write the CSR
    logic rd_kill;  // old value is not returned to rd
  } csr_dec_t;

  function automatic csr_dec_t csr_decode(input logic [1:0] op,
                                          input logic       rd_zero,
                                          input logic       src_zero);
    csr_dec_t d;
    d.op_ok   = (op != CSR_OP_ILL);
    // RW always writes; RS/RC with a zero source are pure reads
    d.wr_req  = (op == CSR_OP_RW) | ~src_zero;
    d.rd_kill = (op == CSR_OP_RW) & rd_zero;
    return d;
  endfunction

  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return (addr[11:10] == 2'b11);
  endfunction

endpackage

// File: rtl/csr_rmw_pipe_if.sv
// Request/response bundle between the EX stage and the CSR RMW unit.
interface csr_rmw_pipe_if #(
  parameter int XLEN = 32
);
  logic            req_vld;
  logic            req_rdy;
  logic [1:0]      req_op;
  logic            req_imm_sel;
  logic [XLEN-1:0] req_rs1_data;
  logic [4:0]      req_zimm;
  logic [11:0]     req_addr;
  logic            req_rd_zero;
  logic            req_src_zero;
  logic            rsp_vld;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_illegal;

  modport master (
    output req_vld, req_op, req_imm_sel, req_rs1_data, req_zimm,
           req_addr, req_rd_zero, req_src_zero,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_illegal
  );

  modport slave (
    input  req_vld, req_op, req_imm_sel, req_rs1_data, req_zimm,
           req_addr, req_rd_zero, req_src_zero,
    output req_rdy, rsp_vld, rsp_rdata, rsp_illegal
  );
endinterface

// File: rtl/csr_rmw_pipe_bank.sv
// CSR storage: NUM_CSR x XLEN flops, one synchronous write port and one
// combinational read port, cleared by the asynchronous reset.
module csr_rmw_pipe_bank #(
  parameter int XLEN    = 32,
  parameter int NUM_CSR = 8,
  parameter int IDXW    = $clog2(NUM_CSR)
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [XLEN-1:0] wr_data,
  input  logic [IDXW-1:0] rd_idx,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0]    regs_reg [NUM_CSR];
  logic [NUM_CSR-1:0] wr_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CSR; gi++) begin : g_hit
      assign wr_hit[gi] = wr_en && (wr_idx == IDXW'(gi));
    end
  endgenerate

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NUM_CSR; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CSR; i++) begin
        if (wr_hit[i]) regs_reg[i] <= wr_data;
      end
    end
  end

  assign rd_data = regs_reg[rd_idx];

endmodule

// File: rtl/csr_rmw_pipe.sv
// CSR read-modify-write unit: decode and RMW in the accept cycle, response and
// pending write one edge later, commit the edge after. CSR_COUNTER_EN adds a cycle counter.
module csr_rmw_pipe
  import csr_rmw_pipe_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NUM_CSR  = 8,
  parameter logic [11:0] CSR_BASE = 12'h300
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          stall,
  input  logic          flush,
  csr_rmw_pipe_if.slave bus
);

  localparam int IDXW = $clog2(NUM_CSR);

  logic            accept;
  logic            in_window;
  logic            is_cycle;
  logic            is_cycleh;
  logic            illegal;
  logic            bypass;
  logic            do_write;
  logic            bank_wr_en;
  csr_dec_t        dec;
  logic [IDXW-1:0] idx;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] bank_rdata;
  logic [XLEN-1:0] cnt_rdata;
  logic [XLEN-1:0] rdata_next;
  logic [63:0]     cycle_reg;

  logic            rsp_vld_reg;
  logic            rsp_illegal_reg;
  logic [XLEN-1:0] rsp_rdata_reg;
  logic            pend_vld_reg;
  logic [IDXW-1:0] pend_idx_reg;
  logic [XLEN-1:0] pend_data_reg;

`ifdef CSR_COUNTER_EN
  localparam bit CNT_EN = 1'b1;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) cycle_reg <= '0;
    else       cycle_reg <= cycle_reg + 64'd1;
  end
`else
  localparam bit CNT_EN = 1'b0;

  assign cycle_reg = '0;
`endif

  assign accept      = bus.req_vld & ~stall & ~flush;
  assign bus.req_rdy = ~stall;

  // Range check on 13 bits so a window ending at 12'hFFF cannot wrap
  assign in_window = (bus.req_addr >= CSR_BASE) &&
                     ({1'b0, bus.req_addr} < ({1'b0, CSR_BASE} + 13'(NUM_CSR)));
  assign idx       = IDXW'(bus.req_addr - CSR_BASE);

  // The high half only exists as a separate CSR on 32-bit cores
  assign is_cycle  = CNT_EN && (bus.req_addr == CSR_ADDR_CYCLE);
  assign is_cycleh = CNT_EN && (XLEN == 32) && (bus.req_addr == CSR_ADDR_CYCLEH);
  assign cnt_rdata = is_cycleh ? XLEN'(cycle_reg[63:32]) : XLEN'(cycle_reg);

  always_comb begin
    dec     = csr_decode(bus.req_op, bus.req_rd_zero, bus.req_src_zero);
    illegal = ~dec.op_ok
            | ~(in_window | is_cycle | is_cycleh)
            | (csr_is_read_only(bus.req_addr) & dec.wr_req);
    src     = bus.req_imm_sel ? XLEN'(bus.req_zimm) : bus.req_rs1_data;
    // The previous access's write has not reached the bank yet
    bypass  = pend_vld_reg && (pend_idx_reg == idx);

    if (is_cycle | is_cycleh) old_val = cnt_rdata;
    else if (bypass)          old_val = pend_data_reg;
    else                      old_val = bank_rdata;

    case (bus.req_op)
      CSR_OP_RS: new_val = old_val | src;
      CSR_OP_RC: new_val = old_val & ~src;
      default:   new_val = src;
    endcase

    do_write   = accept & ~illegal & dec.wr_req;
    rdata_next = (illegal | dec.rd_kill) ? '0 : old_val;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rsp_vld_reg     <= 1'b0;
      rsp_illegal_reg <= 1'b0;
      rsp_rdata_reg   <= '0;
      pend_vld_reg    <= 1'b0;
      pend_idx_reg    <= '0;
      pend_data_reg   <= '0;
    end else begin
      if (flush) begin
        rsp_vld_reg     <= 1'b0;
        rsp_illegal_reg <= 1'b0;
        rsp_rdata_reg   <= '0;
      end else if (!stall) begin
        rsp_vld_reg     <= accept;
        rsp_illegal_reg <= accept & illegal;
        if (accept) rsp_rdata_reg <= rdata_next;
      end
      pend_vld_reg <= do_write;
      if (do_write) begin
        pend_idx_reg  <= idx;
        pend_data_reg <= new_val;
      end
    end
  end

  // A flush kills the instruction whose write is still pending
  assign bank_wr_en = pend_vld_reg & ~flush;

  csr_rmw_pipe_bank #(
    .XLEN    (XLEN),
    .NUM_CSR (NUM_CSR),
    .IDXW    (IDXW)
  ) u_bank (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .wr_en   (bank_wr_en),
    .wr_idx  (pend_idx_reg),
    .wr_data (pend_data_reg),
    .rd_idx  (idx),
    .rd_data (bank_rdata)
  );

  assign bus.rsp_vld     = rsp_vld_reg;
  assign bus.rsp_rdata   = rsp_rdata_reg;
  assign bus.rsp_illegal = rsp_illegal_reg;

endmodule
